// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, fetch queue toward decode, EX redirects.
// Optional FETCH_BYPASS_EN: a response arriving while the queue is empty is presented to decode the same cycle.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FQ_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [31:0]   q_instr [FQ_DEPTH];
    logic [31:0]   q_pc    [FQ_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_target;
    logic          req_fire;
    logic          resp_keep;
    logic          bypass_hit;
    logic          q_valid;
    logic          enq;
    logic          deq;
    logic          unused_low_bits;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];

    // Credits come from registered counts only, so id_ready never reaches the request path.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_LIM);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign q_valid   = (count != '0);
    assign resp_keep = imem_resp_valid && (drop == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = imem_resp_valid && (drop == '0) && !q_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign id_valid = q_valid || bypass_hit;
    assign deq      = q_valid && id_ready;
    assign enq      = resp_keep && !(bypass_hit && id_ready);

    always_comb begin
        id_instr = '0;
        id_pc    = '0;
        if (q_valid) begin
            id_instr = q_instr[head];
            id_pc    = q_pc[head];
        end else if (bypass_hit) begin
            id_instr = imem_resp_data;
            id_pc    = resp_pc;
        end
    end

    assign id_pc_plus4 = id_valid ? (id_pc + 32'd4) : '0;

    // resp_pc tracks the address of the next non-dropped response; kept responses are consecutive from the last redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                pc      <= redirect_target;
                resp_pc <= redirect_target;
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                drop    <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (imem_resp_valid) begin
                    if (drop != '0) begin
                        drop <= drop - CW'(1);
                    end else begin
                        resp_pc <= resp_pc + 32'd4;
                    end
                end
                if (enq) begin
                    tail <= tail + PW'(1);
                end
                if (deq) begin
                    head <= head + PW'(1);
                end
                count <= count + CW'(enq) - CW'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            q_instr[tail] <= imem_resp_data;
            q_pc[tail]    <= resp_pc;
        end
    end

endmodule
